// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter byte stream between NUM_REQ
// requesters. Round-robin, packet-locked grants with a per-grant byte limit
// and a programmable idle gap between packets on the line.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_PKT_BYTES = 64,
    parameter int GAP_CLKS      = 16,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   grant_valid,
    output logic [ID_W-1:0]        grant_id,
    output logic                   err_trunc
);

    localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);
    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CLKS > 0) ? GAP_W'(GAP_CLKS - 1) : {GAP_W{1'b0}};
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_r, state_n;
    logic [ID_W-1:0]  rr_ptr_r, rr_ptr_n;
    logic [ID_W-1:0]  grant_id_r, grant_id_n;
    logic             grant_valid_r, grant_valid_n;
    logic [CNT_W-1:0] byte_cnt_r, byte_cnt_n;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_n;
    logic             err_trunc_r, err_trunc_n;

    logic [ID_W-1:0]  pick_s;
    logic             pick_found_s;
    logic             owner_last_s;
    logic             accept_s;
    logic             at_limit_s;
    logic             pkt_end_s;
    logic             trunc_s;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_id;
        logic            hit;
        pick_found_s = 1'b0;
        pick_s       = '0;
        cand         = 0;
        cand_id      = '0;
        hit          = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand         = (int'(rr_ptr_r) + i) % NUM_REQ;
            cand_id      = ID_W'(cand);
            hit          = !pick_found_s && req_valid[cand_id];
            pick_s       = hit ? cand_id : pick_s;
            pick_found_s = pick_found_s | hit;
        end
    end

    // Combinational forwarding between the current owner and the transmitter.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        if (state_r == ST_GRANT) begin
            tx_valid              = req_valid[grant_id_r];
            tx_data               = req_data[{grant_id_r, 3'b000} +: 8];
            req_ready[grant_id_r] = tx_ready;
        end else begin
            tx_valid = 1'b0;
        end
    end

    assign owner_last_s = req_last[grant_id_r];
    assign accept_s     = tx_valid & tx_ready;
    assign at_limit_s   = (byte_cnt_r == CNT_LAST);
    assign pkt_end_s    = accept_s & (owner_last_s | at_limit_s);
    assign trunc_s      = accept_s & ~owner_last_s & at_limit_s;

    // Next-state logic: arbitration, packet lock, byte limit and idle gap.
    always_comb begin
        state_n       = state_r;
        rr_ptr_n      = rr_ptr_r;
        grant_id_n    = grant_id_r;
        grant_valid_n = grant_valid_r;
        byte_cnt_n    = byte_cnt_r;
        gap_cnt_n     = gap_cnt_r;
        err_trunc_n   = trunc_s;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_id_n    = pick_s;
                    rr_ptr_n      = (pick_s == ID_LAST) ? {ID_W{1'b0}} : pick_s + ID_W'(1);
                    byte_cnt_n    = '0;
                    grant_valid_n = 1'b1;
                    state_n       = ST_GRANT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (pkt_end_s) begin
                    grant_valid_n = 1'b0;
                    gap_cnt_n     = '0;
                    state_n       = (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
                end else if (accept_s) begin
                    byte_cnt_n = byte_cnt_r + CNT_W'(1);
                end else begin
                    byte_cnt_n = byte_cnt_r;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_n = '0;
                    state_n   = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt_r + GAP_W'(1);
                end
            end
            default: begin
                state_n       = ST_IDLE;
                grant_valid_n = 1'b0;
                gap_cnt_n     = '0;
            end
        endcase
    end

    // State and control registers; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            grant_id_r    <= '0;
            grant_valid_r <= 1'b0;
            byte_cnt_r    <= '0;
            gap_cnt_r     <= '0;
            err_trunc_r   <= 1'b0;
        end else begin
            state_r       <= state_n;
            rr_ptr_r      <= rr_ptr_n;
            grant_id_r    <= grant_id_n;
            grant_valid_r <= grant_valid_n;
            byte_cnt_r    <= byte_cnt_n;
            gap_cnt_r     <= gap_cnt_n;
            err_trunc_r   <= err_trunc_n;
        end
    end

    assign grant_valid = grant_valid_r;
    assign grant_id    = grant_id_r;
    assign err_trunc   = err_trunc_r;

endmodule
